// File: rtl/branch_history_table.sv
// branch_history_table: 2-bit saturating direction predictor with a two-stage update
// pipeline and saturating resolve/mispredict counters.
module branch_history_table #(
    parameter int         ENTRIES  = 64,
    parameter int         IDX_W    = 6,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] lookup_pc,
    output logic        predict_taken,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic        upd_predicted,
    output logic        mispredict,
    output logic        upd_busy,
    output logic [31:0] mispredict_cnt,
    output logic [31:0] resolve_cnt
);
    logic [1:0]       ctrTable [ENTRIES];
    logic             s1Valid;
    logic [IDX_W-1:0] s1Idx;
    logic             s1Taken;
    logic [1:0]       cur;
    logic [1:0]       nxt;
    logic             miss;
    logic             unusedBits;

    // The table is written at the edge that closes S2, so a back-to-back update to the
    // same index already reads the freshly written value here: forwarding is implicit.
    assign cur = ctrTable[s1Idx];
    assign nxt = s1Taken ? ((cur == 2'b11) ? cur : cur + 2'b01)
                         : ((cur == 2'b00) ? cur : cur - 2'b01);
    assign miss = upd_valid & (upd_taken ^ upd_predicted);
    assign predict_taken = ctrTable[lookup_pc[IDX_W-1:0]][1];
    assign upd_busy = s1Valid;
    assign unusedBits = ^{lookup_pc[31:IDX_W], upd_pc[31:IDX_W]};

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) ctrTable[i] <= CNT_INIT;
            s1Valid        <= 1'b0;
            s1Idx          <= '0;
            s1Taken        <= 1'b0;
            mispredict     <= 1'b0;
            mispredict_cnt <= '0;
            resolve_cnt    <= '0;
        end else begin
            if (s1Valid) ctrTable[s1Idx] <= nxt;
            s1Valid    <= upd_valid;
            s1Idx      <= upd_pc[IDX_W-1:0];
            s1Taken    <= upd_taken;
            mispredict <= miss;
            if (upd_valid) begin
                resolve_cnt    <= resolve_cnt + {31'b0, ~&resolve_cnt};
                mispredict_cnt <= mispredict_cnt + {31'b0, miss & ~&mispredict_cnt};
            end
        end
    end
endmodule
